atmr_vote_monitor: RTL and testbench
====================================

// Module: atmr_vote_monitor
// PURPOSE
//  Registered downstream stage for an ATMR-protected combinational block (10-output, 3 copies).
//  - Consumes the three redundant output words: ori, mai, men.
//  - Produces the registered bitwise majority vote.
//  - Counts per-copy disagreements with the vote over fixed sample windows.
//  - Raises sticky fault flags when a copy disagrees too often; expected approximation mismatches stay below threshold.
// PARAMETERS
//  W       10   width of each redundant output word
//  WINDOW  256  accepted samples per evaluation window (>=2)
//  THRESH  16   mismatches per window at/above which a copy is flagged (1..WINDOW)
//  CNT_W   9    width of mismatch counters; must hold WINDOW
// PORTS
//  clk         in   1      single clock; all state on rising edge
//  rst_n       in   1      synchronous active-low reset
//  in_valid    in   1      ori_z/mai_z/men_z hold a sample this cycle
//  ori_z       in   W      output word of exact copy
//  mai_z       in   W      output word of approximate copy A
//  men_z       in   W      output word of approximate copy B
//  clr         in   1      synchronous clear of counters, window and fault flags
//  z           out  W      registered majority vote
//  out_valid   out  1      z valid; one-cycle pulse per accepted sample
//  no_major    out  1      registered with z: all three words pairwise different
//  mis_ori     out  CNT_W  ori mismatches in current window
//  mis_mai     out  CNT_W  mai mismatches in current window
//  mis_men     out  CNT_W  men mismatches in current window
//  fault       out  3      sticky flags {men,mai,ori}
//  win_done    out  1      one-cycle pulse in EVAL state
// BEHAVIOUR
//  Reset (rst_n=0 at edge)
//   - All outputs and counters go to 0; state goes to ACCUM.
//   - Reset mid-window discards the partial window.
//  Vote
//   - Per bit: v = (o&a)|(o&m)|(a&m).
//   - On in_valid: z<=v, no_major<=(o!=a)&(o!=m)&(a!=m), out_valid<=1.
//   - Without in_valid: out_valid<=0; z and no_major hold.
//   - Latency: exactly 1 cycle. No backpressure.
//  Mismatch counting (accepted samples only)
//   - A copy mismatches when its full word != v.
//   - Each counter saturates at 2^CNT_W-1.
//   - win_cnt increments per accepted sample.
//  FSM
//   - ACCUM: count samples. An accepted sample with win_cnt==WINDOW-1 goes to EVAL; that sample is counted first.
//   - EVAL (1 cycle), using the counts including the last sample:
//     - fault[i] |= (mis_i >= THRESH).
//     - win_done=1; win_cnt, mis_* cleared; return to ACCUM.
//     - An in_valid sample during EVAL is voted normally. Its mismatches seed the new window: counter=1 or 0, win_cnt=1.
//  clr
//   - Clears mis_*, win_cnt and fault; state goes to ACCUM.
//   - The vote path is unaffected.
//   - Priority: rst_n > clr > EVAL > counting.
//   - clr during EVAL suppresses the flag update; win_done stays 0.
//  Fault flags
//   - Sticky until clr or reset.
//   - Flags never alter the vote.
// TESTING
//  1. Reset, then o=a=m=0x155 valid 1 cycle -> next cycle z=0x155, out_valid=1, no_major=0, mis_*=0.
//  2. o=0x3FF, a=0x000, m=0x0F0 -> z=0x0F0, no_major=1, mis_ori=1, mis_mai=1, mis_men=0.
//  3. WINDOW=8, THRESH=2; 8 samples with mai differing twice -> EVAL: win_done pulses, fault=3'b010, counters back to 0.
//  4. Same config, mai differs once per window for 3 windows -> fault stays 0; win_done pulses 3 times.
//  5. in_valid held through EVAL with men mismatching on that sample -> mis_men=1, win_cnt=1 after EVAL.
//  6. clr asserted in EVAL cycle with mis_ori>=THRESH -> fault stays 0, counters 0; rst_n=0 mid-window -> all outputs 0 next cycle.

Source files
------------

// File: rtl/atmr_vote_monitor.sv
// Registered majority voter for three redundant copies of a combinational block.
// Per-copy disagreement with the vote is counted over fixed sample windows, and
// sticky fault flags mark copies whose mismatch rate reaches the threshold.
module atmr_vote_monitor #(
    parameter int unsigned W      = 10,
    parameter int unsigned WINDOW = 256,
    parameter int unsigned THRESH = 16,
    parameter int unsigned CNT_W  = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     ori_z,
    input  logic [W-1:0]     mai_z,
    input  logic [W-1:0]     men_z,
    input  logic             clr,
    output logic [W-1:0]     z,
    output logic             out_valid,
    output logic             no_major,
    output logic [CNT_W-1:0] mis_ori,
    output logic [CNT_W-1:0] mis_mai,
    output logic [CNT_W-1:0] mis_men,
    output logic [2:0]       fault,
    output logic             win_done
);

    typedef enum logic [0:0] {
        StAccum,
        StEval
    } state_e;

    localparam logic [CNT_W-1:0] WinLast = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] Thresh  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [W-1:0]     z_q;
    logic             out_valid_q, no_major_q;
    logic [CNT_W-1:0] mis_ori_q, mis_ori_d;
    logic [CNT_W-1:0] mis_mai_q, mis_mai_d;
    logic [CNT_W-1:0] mis_men_q, mis_men_d;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [2:0]       fault_q, fault_d;
    logic             win_done_d;

    logic [W-1:0]     vote;
    logic             vote_no_major;
    logic             mm_ori, mm_mai, mm_men;

    // Bitwise 2-of-3 vote and whole-word disagreement of each copy with it.
    assign vote          = (ori_z & mai_z) | (ori_z & men_z) | (mai_z & men_z);
    assign vote_no_major = (ori_z != mai_z) && (ori_z != men_z) && (mai_z != men_z);
    assign mm_ori        = (ori_z != vote);
    assign mm_mai        = (mai_z != vote);
    assign mm_men        = (men_z != vote);

    // Saturating increment so counters never wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic hit);
        if (hit && (cnt != {CNT_W{1'b1}})) begin
            return cnt + CntOne;
        end
        return cnt;
    endfunction

    // Vote path: registered result, independent of clr and the window FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q         <= '0;
            no_major_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (in_valid) begin
            z_q         <= vote;
            no_major_q  <= vote_no_major;
            out_valid_q <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    // Window FSM next state, counters and flag update; clr outranks EVAL.
    always_comb begin
        state_d    = state_q;
        mis_ori_d  = mis_ori_q;
        mis_mai_d  = mis_mai_q;
        mis_men_d  = mis_men_q;
        win_cnt_d  = win_cnt_q;
        fault_d    = fault_q;
        win_done_d = 1'b0;
        if (clr) begin
            state_d   = StAccum;
            mis_ori_d = '0;
            mis_mai_d = '0;
            mis_men_d = '0;
            win_cnt_d = '0;
            fault_d   = '0;
        end else begin
            unique case (state_q)
                StEval: begin
                    win_done_d = 1'b1;
                    fault_d    = fault_q | {mis_men_q >= Thresh,
                                            mis_mai_q >= Thresh,
                                            mis_ori_q >= Thresh};
                    state_d    = StAccum;
                    // A sample arriving now opens the next window.
                    if (in_valid) begin
                        mis_ori_d = CNT_W'(mm_ori);
                        mis_mai_d = CNT_W'(mm_mai);
                        mis_men_d = CNT_W'(mm_men);
                        win_cnt_d = CntOne;
                    end else begin
                        mis_ori_d = '0;
                        mis_mai_d = '0;
                        mis_men_d = '0;
                        win_cnt_d = '0;
                    end
                end
                default: begin
                    if (in_valid) begin
                        mis_ori_d = sat_inc(mis_ori_q, mm_ori);
                        mis_mai_d = sat_inc(mis_mai_q, mm_mai);
                        mis_men_d = sat_inc(mis_men_q, mm_men);
                        win_cnt_d = win_cnt_q + CntOne;
                        if (win_cnt_q == WinLast) begin
                            state_d = StEval;
                        end
                    end
                end
            endcase
        end
    end

    // Window state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StAccum;
            mis_ori_q <= '0;
            mis_mai_q <= '0;
            mis_men_q <= '0;
            win_cnt_q <= '0;
            fault_q   <= '0;
        end else begin
            state_q   <= state_d;
            mis_ori_q <= mis_ori_d;
            mis_mai_q <= mis_mai_d;
            mis_men_q <= mis_men_d;
            win_cnt_q <= win_cnt_d;
            fault_q   <= fault_d;
        end
    end

    assign z         = z_q;
    assign out_valid = out_valid_q;
    assign no_major  = no_major_q;
    assign mis_ori   = mis_ori_q;
    assign mis_mai   = mis_mai_q;
    assign mis_men   = mis_men_q;
    assign fault     = fault_q;
    assign win_done  = win_done_d;

endmodule

// File: tb/tb_atmr_vote_monitor.sv
// Scoreboard bench for atmr_vote_monitor: the driver pushes expected responses
// computed by a window-level reference model; the monitor pops on out_valid.
module tb_atmr_vote_monitor;

    localparam int unsigned W      = 10;
    localparam int unsigned WINDOW = 8;
    localparam int unsigned THRESH = 2;
    localparam int unsigned CNT_W  = 9;
    localparam int          MAXC   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [W-1:0]     ori_z, mai_z, men_z;
    logic             clr;
    logic [W-1:0]     z;
    logic             out_valid, no_major;
    logic [CNT_W-1:0] mis_ori, mis_mai, mis_men;
    logic [2:0]       fault;
    logic             win_done;

    atmr_vote_monitor #(
        .W      (W),
        .WINDOW (WINDOW),
        .THRESH (THRESH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .ori_z     (ori_z),
        .mai_z     (mai_z),
        .men_z     (men_z),
        .clr       (clr),
        .z         (z),
        .out_valid (out_valid),
        .no_major  (no_major),
        .mis_ori   (mis_ori),
        .mis_mai   (mis_mai),
        .mis_men   (mis_men),
        .fault     (fault),
        .win_done  (win_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] z;
        bit           nm;
        int           mo, ma, mn;
        bit [2:0]     f;
        bit           wd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   wd_seen = 0;
    bit   mon_en = 1'b0;

    // Reference model state: samples in the open window, per-copy counts,
    // flags, and a completed window whose flag fold is still pending.
    int       wpos, mo, ma, mn;
    bit [2:0] mfault, pflags;
    bit       pend;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [W-1:0] ref_vote(input logic [W-1:0] o, a, m);
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) begin
            int ones;
            ones = int'(o[i]) + int'(a[i]) + int'(m[i]);
            v[i] = (ones >= 2);
        end
        return v;
    endfunction

    function automatic int sat(input int x);
        return (x > MAXC) ? MAXC : x;
    endfunction

    function automatic void model_reset();
        wpos = 0; mo = 0; ma = 0; mn = 0;
        mfault = '0; pflags = '0; pend = 1'b0;
        q.delete();
    endfunction

    function automatic void model_step(input bit v, input logic [W-1:0] o, a, m, input bit c);
        exp_t e;
        logic [W-1:0] vt;
        if (pend) begin
            if (!c) mfault |= pflags;
            pend = 1'b0;
        end
        vt   = ref_vote(o, a, m);
        e.z  = vt;
        e.nm = (o != a) && (o != m) && (a != m);
        if (c) begin
            wpos = 0; mo = 0; ma = 0; mn = 0; mfault = '0;
            if (v) begin
                e.mo = 0; e.ma = 0; e.mn = 0; e.f = '0; e.wd = 1'b0;
                q.push_back(e);
            end
        end else if (v) begin
            mo = sat(mo + ((o != vt) ? 1 : 0));
            ma = sat(ma + ((a != vt) ? 1 : 0));
            mn = sat(mn + ((m != vt) ? 1 : 0));
            wpos++;
            e.mo = mo; e.ma = ma; e.mn = mn; e.f = mfault;
            e.wd = (wpos == WINDOW);
            q.push_back(e);
            if (wpos == WINDOW) begin
                pflags = {mn >= THRESH, ma >= THRESH, mo >= THRESH};
                pend   = 1'b1;
                wpos = 0; mo = 0; ma = 0; mn = 0;
            end
        end
    endfunction

    task automatic cycle(input bit v, input logic [W-1:0] o, a, m, input bit c);
        in_valid = v; ori_z = o; mai_z = a; men_z = m; clr = c;
        model_step(v, o, a, m, c);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit c);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, c);
    endtask

    // One accepted sample; copies flagged in bad[2:0] = {men,mai,ori} get corrupted.
    task automatic sample(input bit [2:0] bad);
        logic [W-1:0] base, o, a, m;
        base = W'($urandom);
        o = bad[0] ? base ^ W'($urandom_range(1, (1 << W) - 1)) : base;
        a = bad[1] ? base ^ W'($urandom_range(1, (1 << W) - 1)) : base;
        m = bad[2] ? base ^ W'($urandom_range(1, (1 << W) - 1)) : base;
        cycle(1'b1, o, a, m, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0;
        ori_z = '0; mai_z = '0; men_z = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_z", 32'(z), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_no_major", 32'(no_major), 0);
        chk("rst_mis", {mis_ori, mis_mai, mis_men}, 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_win_done", 32'(win_done), 0);
    endtask

    // Monitor: compare every presented output against the oldest expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (win_done === 1'b1) wd_seen++;
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got 1, expected no pending sample");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("z", 32'(z), 32'(e.z));
                    chk("no_major", 32'(no_major), 32'(e.nm));
                    chk("mis_ori", 32'(mis_ori), 32'(e.mo));
                    chk("mis_mai", 32'(mis_mai), 32'(e.ma));
                    chk("mis_men", 32'(mis_men), 32'(e.mn));
                    chk("fault", 32'(fault), 32'(e.f));
                    chk("win_done", 32'(win_done), 32'(e.wd && !clr));
                end
            end else begin
                chk("win_done_idle", 32'(win_done), 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int wd0;
        rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0;
        ori_z = '0; mai_z = '0; men_z = '0;
        @(posedge clk);
        #1;
        do_reset();
        mon_en = 1'b1;

        // All equal, then fully split vote.
        cycle(1'b1, 10'h155, 10'h155, 10'h155, 1'b0);
        cycle(1'b1, 10'h3FF, 10'h000, 10'h0F0, 1'b0);
        idle(1, 1'b0);

        // mai wrong twice in one window.
        idle(1, 1'b1);
        for (int k = 0; k < WINDOW; k++) sample((k == 2 || k == 5) ? 3'b010 : 3'b000);
        idle(1, 1'b0);
        chk("t3_fault", 32'(fault), 32'h2);
        chk("t3_mis_cleared", {mis_ori, mis_mai, mis_men}, 0);

        // mai wrong once per window, three windows, gaps in between.
        idle(1, 1'b1);
        wd0 = wd_seen;
        for (int w = 0; w < 3; w++) begin
            int pos;
            pos = $urandom_range(0, WINDOW - 1);
            for (int k = 0; k < WINDOW; k++) begin
                sample((k == pos) ? 3'b010 : 3'b000);
                if ($urandom_range(0, 2) == 0) idle(1, 1'b0);
            end
        end
        idle(2, 1'b0);
        chk("t4_fault", 32'(fault), 0);
        chk("t4_win_done_pulses", 32'(wd_seen - wd0), 3);

        // Valid held through EVAL; men wrong on the sample that seeds the next window.
        for (int k = 0; k < WINDOW; k++) sample(3'b000);
        sample(3'b100);
        for (int k = 1; k < WINDOW; k++) sample(3'b000);
        sample(3'b000);
        idle(2, 1'b0);

        // clr in the EVAL cycle hides an ori fault.
        idle(1, 1'b1);
        for (int k = 0; k < WINDOW; k++) sample((k < 3) ? 3'b001 : 3'b000);
        idle(1, 1'b1);
        chk("t6_fault_suppressed", 32'(fault), 0);
        chk("t6_mis_cleared", {mis_ori, mis_mai, mis_men}, 0);

        // Randomised traffic with occasional clr.
        for (int i = 0; i < 1500; i++) begin
            bit [2:0] bad;
            bad[0] = ($urandom_range(0, 39) == 0);
            bad[1] = ($urandom_range(0, 5) == 0);
            bad[2] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) == 0) idle(1, 1'b1);
            else if ($urandom_range(0, 3) == 0) idle(1, 1'b0);
            else sample(bad);
        end

        // Reset mid-window discards the partial window.
        for (int k = 0; k < 3; k++) sample(3'b011);
        idle(1, 1'b0);
        do_reset();
        for (int k = 0; k < WINDOW + 2; k++) sample((k == 0) ? 3'b001 : 3'b000);
        idle(3, 1'b0);
        chk("queue_drained", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
